// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/MEM/HALT sequencer with a stallable data-memory port.
// Optional carry flag and carry-aware SKZ when ACC_CPU_CARRY_EN is defined.
module acc_cpu_mc #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int OP_W   = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [ADDR_W-1:0]      im_addr,
   input  logic [OP_W+ADDR_W-1:0] im_in,
   output logic                   rd_mem,
   output logic                   wr_mem,
   output logic [ADDR_W-1:0]      dm_addr,
   output logic [DATA_W-1:0]      dm_in,
   input  logic [DATA_W-1:0]      dm_out,
   input  logic                   dm_rdy,
   input  logic                   resume,
   output logic [DATA_W-1:0]      ac_out,
   output logic [DATA_W-1:0]      alu_out,
   output logic [OP_W-1:0]        op,
   output logic                   halted
`ifdef ACC_CPU_CARRY_EN
   ,
   output logic                   carry
`endif
);

   // state   | meaning
   // S_FETCH | latch instruction at PC into IR
   // S_DECODE| dispatch: branch/skip/halt resolve here, memory ops raise request
   // S_MEM   | hold request until dm_rdy, then commit AC (reads) and advance PC
   // S_HALT  | halted=1, wait for resume
   typedef enum logic [1:0] {S_FETCH, S_DECODE, S_MEM, S_HALT} state_t;

   localparam logic [OP_W-1:0] OP_SKZ = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
   localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
   localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
   localparam logic [OP_W-1:0] OP_LDA = OP_W'(5);
   localparam logic [OP_W-1:0] OP_STO = OP_W'(6);
   localparam logic [OP_W-1:0] OP_JMP = OP_W'(7);

   state_t                  state, state_nxt;
   logic [ADDR_W-1:0]       pc, pc_nxt;
   logic [OP_W+ADDR_W-1:0]  ir, ir_nxt;
   logic [DATA_W-1:0]       ac, ac_nxt;
   logic                    rd_q, rd_nxt, wr_q, wr_nxt;
   logic                    skip;

`ifdef ACC_CPU_CARRY_EN
   logic                    carry_q, carry_nxt;
   logic [DATA_W:0]         sum;
   assign sum   = {1'b0, ac} + {1'b0, dm_out};
   assign skip  = (ac == '0) || carry_q;
   assign carry = carry_q;
`else
   logic [DATA_W-1:0]       sum;
   assign sum  = ac + dm_out;
   assign skip = (ac == '0);
`endif

   assign im_addr = pc;
   assign op      = ir[OP_W+ADDR_W-1:ADDR_W];
   assign dm_addr = ir[ADDR_W-1:0];
   assign dm_in   = ac;
   assign ac_out  = ac;
   assign rd_mem  = rd_q;
   assign wr_mem  = wr_q;
   assign halted  = (state == S_HALT);

   always_comb begin
      alu_out = ac;
      case (op)
         OP_ADD:  alu_out = sum[DATA_W-1:0];
         OP_AND:  alu_out = ac & dm_out;
         OP_XOR:  alu_out = ac ^ dm_out;
         OP_LDA:  alu_out = dm_out;
         default: alu_out = ac;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_FETCH;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      ir_nxt    = ir;
      ac_nxt    = ac;
      rd_nxt    = rd_q;
      wr_nxt    = wr_q;
`ifdef ACC_CPU_CARRY_EN
      carry_nxt = carry_q;
`endif
      case (state)
         S_FETCH: begin
            ir_nxt    = im_in;
            state_nxt = S_DECODE;
         end
         S_DECODE: begin
            case (op)
               OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
                  rd_nxt    = 1'b1;
                  state_nxt = S_MEM;
               end
               OP_STO: begin
                  wr_nxt    = 1'b1;
                  state_nxt = S_MEM;
               end
               OP_JMP: begin
                  pc_nxt    = dm_addr;
                  state_nxt = S_FETCH;
               end
               OP_SKZ: begin
                  pc_nxt    = skip ? pc + ADDR_W'(2) : pc + ADDR_W'(1);
                  state_nxt = S_FETCH;
               end
               default: state_nxt = S_HALT;
            endcase
         end
         S_MEM: begin
            // request stays asserted with operand/data untouched until memory completes
            if (dm_rdy) begin
               if (rd_q) begin
                  ac_nxt = alu_out;
`ifdef ACC_CPU_CARRY_EN
                  carry_nxt = (op == OP_ADD) ? sum[DATA_W] : 1'b0;
`endif
               end
               pc_nxt    = pc + ADDR_W'(1);
               rd_nxt    = 1'b0;
               wr_nxt    = 1'b0;
               state_nxt = S_FETCH;
            end
         end
         S_HALT: begin
            if (resume) begin
               pc_nxt    = pc + ADDR_W'(1);
               state_nxt = S_FETCH;
            end
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc   <= '0;
         ir   <= '0;
         ac   <= '0;
         rd_q <= 1'b0;
         wr_q <= 1'b0;
`ifdef ACC_CPU_CARRY_EN
         carry_q <= 1'b0;
`endif
      end else begin
         pc   <= pc_nxt;
         ir   <= ir_nxt;
         ac   <= ac_nxt;
         rd_q <= rd_nxt;
         wr_q <= wr_nxt;
`ifdef ACC_CPU_CARRY_EN
         carry_q <= carry_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Bench for acc_cpu_mc: directed program checks plus randomized programs scored against an ISA-level model.
module tb_acc_cpu_mc;

   logic       clk, rst;
   logic [4:0] im_addr, dm_addr;
   logic [7:0] im_in, dm_in, dm_out, ac_out, alu_out;
   logic       rd_mem, wr_mem, dm_rdy, resume, halted;
   logic [2:0] op;
`ifdef ACC_CPU_CARRY_EN
   logic       carry;
`endif

   logic [7:0] imem [32];
   logic [7:0] dmem [32];

   assign im_in  = imem[im_addr];
   assign dm_out = dmem[dm_addr];

   acc_cpu_mc #(.DATA_W(8), .ADDR_W(5), .OP_W(3)) dut (
      .clk(clk), .rst(rst), .im_addr(im_addr), .im_in(im_in),
      .rd_mem(rd_mem), .wr_mem(wr_mem), .dm_addr(dm_addr), .dm_in(dm_in),
      .dm_out(dm_out), .dm_rdy(dm_rdy), .resume(resume), .ac_out(ac_out),
      .alu_out(alu_out), .op(op), .halted(halted)
`ifdef ACC_CPU_CARRY_EN
      , .carry(carry)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // expected observable events: 0 = read, 1 = write, 2 = halt entry
   typedef struct {
      int kind;
      int addr;
      int data;
   } ev_t;
   ev_t exp_q[$];
   logic sb_en = 1'b0;
   logic halted_q = 1'b0;

   always @(negedge clk) begin
      ev_t e;
      if (sb_en) begin
         chk("rd_wr_exclusive", int'(rd_mem && wr_mem), 0);
         if ((rd_mem || wr_mem) && dm_rdy) begin
            if (exp_q.size() == 0) chk("unexpected_mem", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("mem_kind", int'(wr_mem), e.kind);
               chk("mem_addr", int'(dm_addr), e.addr);
               if (e.kind == 1) chk("wr_data", int'(dm_in), e.data);
            end
         end
         if (halted && !halted_q) begin
            if (exp_q.size() == 0) chk("unexpected_halt", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("halt_kind", 2, e.kind);
               chk("halt_pc", int'(im_addr), e.addr);
               chk("halt_ac", int'(ac_out), e.data);
            end
         end
      end
      halted_q <= halted;
   end

   // ISA-level interpreter: runs n instructions from PC=0 and records expected events
   task automatic build_model(input int n);
      int pc = 0, ac = 0, a, opc, c = 0;
      int m [32];
      for (int i = 0; i < 32; i++) m[i] = int'(dmem[i]);
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         opc = int'(imem[pc]) >> 5;
         a   = int'(imem[pc]) & 31;
         case (opc)
            0: begin exp_q.push_back('{2, pc, ac}); pc = (pc + 1) % 32; end
            1: pc = (pc + ((ac == 0 || c == 1) ? 2 : 1)) % 32;
            6: begin exp_q.push_back('{1, a, ac}); m[a] = ac; pc = (pc + 1) % 32; end
            7: pc = a;
            default: begin
               exp_q.push_back('{0, a, 0});
               case (opc)
                  2: begin
`ifdef ACC_CPU_CARRY_EN
                     c = (ac + m[a]) > 255 ? 1 : 0;
`endif
                     ac = (ac + m[a]) % 256;
                  end
                  3: begin ac = ac & m[a]; c = 0; end
                  4: begin ac = ac ^ m[a]; c = 0; end
                  default: begin ac = m[a]; c = 0; end
               endcase
               pc = (pc + 1) % 32;
            end
         endcase
      end
   endtask

   // one clock: memory write commits on the edge, returns 1 time unit after it
   task automatic tick();
      logic       w;
      logic [4:0] a;
      logic [7:0] d;
      w = rst && wr_mem && dm_rdy;
      a = dm_addr;
      d = dm_in;
      @(posedge clk);
      if (w) dmem[a] = d;
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) begin
         imem[i] = 8'h00;
         dmem[i] = 8'h00;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; dm_rdy = 1'b1; resume = 1'b0;
      #2;
      chk("rst_im_addr", int'(im_addr), 0);
      chk("rst_ac", int'(ac_out), 0);
      chk("rst_rd_wr", int'({rd_mem, wr_mem}), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_op", int'(op), 0);
      chk("rst_alu", int'(alu_out), 0);
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic wait_halt(output int n);
      n = 0;
      while (!halted && n < 100) begin tick(); n++; end
   endtask

   task automatic wait_pc(input int target);
      int n = 0;
      while (int'(im_addr) != target && n < 100) begin tick(); n++; end
      chk("wait_pc_timeout", int'(n < 100), 1);
   endtask

   initial begin
      int n, cyc;
      rst = 1'b0; dm_rdy = 1'b1; resume = 1'b0;

      // program LDA 1; ADD 2; STO 3; HLT
      clear_mem();
      imem[0] = 8'hA1; imem[1] = 8'h42; imem[2] = 8'hC3; imem[3] = 8'h00;
      dmem[1] = 8'h05; dmem[2] = 8'hFC;
      do_reset();
      wait_halt(n);
      chk("progA_cycles", n, 11);
      chk("progA_ac", int'(ac_out), 8'h01);
      chk("progA_dmem3", int'(dmem[3]), 8'h01);
      chk("progA_pc", int'(im_addr), 3);

      // same program, ADD stalled 4 cycles
      dmem[3] = 8'h00;
      do_reset();
      n = 0;
      while (!halted && n < 100) begin
         dm_rdy = !(n >= 5 && n < 9);
         if (n >= 5 && n < 9) begin
            chk("stall_rd_mem", int'(rd_mem), 1);
            chk("stall_dm_addr", int'(dm_addr), 2);
            chk("stall_ac", int'(ac_out), 8'h05);
         end
         tick();
         n++;
      end
      chk("stall_cycles", n, 15);
      chk("stall_ac_final", int'(ac_out), 8'h01);

      // SKZ at PC=31 with AC=0 wraps to 1
      clear_mem();
      imem[0] = 8'hFF; imem[31] = 8'h20;
      do_reset();
      wait_pc(31);
      tick(); tick();
      chk("skz_zero_wrap", int'(im_addr), 1);

      // SKZ at PC=31 with AC=7 wraps to 0
      clear_mem();
      imem[0] = 8'hA4; imem[1] = 8'hFF; imem[31] = 8'h20; dmem[4] = 8'h07;
      do_reset();
      wait_pc(31);
      tick(); tick();
      chk("skz_nz_ac", int'(ac_out), 7);
      chk("skz_nz_wrap", int'(im_addr), 0);

      // JMP latency, HLT, resume
      clear_mem();
      imem[0] = 8'hE7; imem[7] = 8'h00;
      do_reset();
      tick(); tick();
      chk("jmp_target", int'(im_addr), 7);
      tick(); tick();
      chk("hlt_halted", int'(halted), 1);
      chk("hlt_pc", int'(im_addr), 7);
      tick();
      chk("hlt_stays", int'(halted), 1);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      chk("resume_halted", int'(halted), 0);
      chk("resume_pc", int'(im_addr), 8);

      // reset asserted during STO memory phase
      clear_mem();
      imem[0] = 8'hA1; imem[1] = 8'hC3; dmem[1] = 8'h05; dmem[3] = 8'h5A;
      do_reset();
      tick(); tick(); tick();
      dm_rdy = 1'b0;
      tick(); tick();
      chk("sto_wr_mem", int'(wr_mem), 1);
      chk("sto_dm_in", int'(dm_in), 8'h05);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_wr_mem", int'(wr_mem), 0);
      chk("rst_mid_pc", int'(im_addr), 0);
      chk("rst_mid_ac", int'(ac_out), 0);
      dm_rdy = 1'b1;
      tick();
      chk("rst_mid_dmem", int'(dmem[3]), 8'h5A);

`ifdef ACC_CPU_CARRY_EN
      clear_mem();
      imem[0] = 8'hA1; imem[1] = 8'h42; dmem[1] = 8'hFF; dmem[2] = 8'h01;
      do_reset();
      for (int i = 0; i < 6; i++) tick();
      chk("carry_ac", int'(ac_out), 0);
      chk("carry_set", int'(carry), 1);
`endif

      // randomized programs scored against the model
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 32; i++) begin
            imem[i] = ($urandom_range(0, 15) == 0) ? 8'(i & 0) : 8'(($urandom_range(1, 7) << 5) | $urandom_range(0, 31));
            dmem[i] = 8'($urandom_range(0, 255));
         end
         build_model(150);
         do_reset();
         sb_en = 1'b1;
         cyc = 0;
         while (exp_q.size() > 0 && cyc < 6000) begin
            dm_rdy = ($urandom_range(0, 2) != 0);
            resume = ($urandom_range(0, 3) == 0);
            tick();
            cyc++;
         end
         chk("sb_drain", exp_q.size(), 0);
         sb_en = 1'b0;
         resume = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
